// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
// Sequencer that drives a registered 3-to-8 active-low LED decoder. It steps
// one lit LED around an 8-LED bar at a programmable rate. Run and pause are
// toggled by a debounced push-button.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bar blanked (enable=000), busy=0, waiting for a press
// RUN   | bar driven (enable=100), prescaler counting, index stepping
// PAUSE | bar driven, index and prescaler frozen until next press
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   run_btn   raw asynchronous push-button, active high; a press toggles run/pause
//   stop      synchronous level; forces IDLE
//   dir       0 = count up, 1 = count down (sampled at each step)
//   one_shot  1 = return to IDLE on the step that wraps the index
//   step_div  one step every step_div+1 cycles while in RUN
//   switch    LED index to the decoder
//   enable    decoder enable (3'b100 = drive, 3'b000 = blank)
//   busy      high in RUN or PAUSE
//   wrap      one-cycle pulse on the step that wraps the index
module led_scan_ctrl #(
  parameter int DIV_W      = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             stop,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [DIV_W-1:0] step_div,
  output logic [2:0]       switch,
  output logic [2:0]       enable,
  output logic             busy,
  output logic             wrap
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;

  state_t           state_q, state_d;
  logic [2:0]       switch_q, switch_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [2:0]       enable_q, enable_d;
  logic             busy_q, busy_d;

  // Debouncer: the accepted level follows the synchronized button only after
  // DEB_CYCLES consecutive disagreeing samples; one agreeing sample restarts it.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_comb begin
    state_d  = state_q;
    switch_d = switch_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_q) begin
            state_d  = ST_RUN;
            switch_d = dir ? 3'd7 : 3'd0;
            cnt_d    = '0;
          end
        end
        ST_RUN: begin
          if (press_q) begin
            state_d = ST_PAUSE;
          end else if (cnt_q >= step_div) begin
            // >= rather than == so lowering step_div mid-run cannot stall.
            cnt_d    = '0;
            switch_d = dir ? (switch_q - 3'd1) : (switch_q + 3'd1);
            wrap_d   = dir ? (switch_q == 3'd0) : (switch_q == 3'd7);
            if (wrap_d && one_shot) begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (press_q) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they move with the state.
    busy_d   = (state_d != ST_IDLE);
    enable_d = busy_d ? 3'b100 : 3'b000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      state_q   <= ST_IDLE;
      switch_q  <= 3'd0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      enable_q  <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= run_btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      switch_q  <= switch_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
    end
  end

  assign switch = switch_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Testbench for led_scan_ctrl: a cycle-level reference model predicts the
// outputs after every clock edge, pushes them into a queue, and a negedge
// monitor pops and compares them against the DUT.
module tb_led_scan_ctrl;
  localparam int DIV_W = 4;
  localparam int DEB   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_btn = 1'b0;
  logic             stop = 1'b0;
  logic             dir = 1'b0;
  logic             one_shot = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
  logic [2:0]       switch;
  logic [2:0]       enable;
  logic             busy;
  logic             wrap;

  led_scan_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .stop(stop), .dir(dir),
    .one_shot(one_shot), .step_div(step_div), .switch(switch),
    .enable(enable), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  // Reference model state (0 idle, 1 run, 2 pause)
  int m_s1, m_s2, m_deb, m_dc, m_press;
  int m_state, m_sw, m_cnt, m_wrap;

  function automatic void check(string name, logic [7:0] got, logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got sw/en/busy/wrap=%b expected %b", name, $time, got, want);
  endfunction

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_dc = 0; m_press = 0;
    m_state = 0; m_sw = 0; m_cnt = 0; m_wrap = 0;
  endfunction

  function automatic logic [7:0] model_out();
    logic [2:0] sw3;
    sw3 = 3'(m_sw);
    return {sw3, (m_state != 0) ? 3'b100 : 3'b000, m_state != 0, m_wrap != 0};
  endfunction

  // Apply one clock edge with the currently driven inputs.
  function automatic void model_clock();
    int nstate = m_state;
    int nsw    = m_sw;
    int ncnt   = m_cnt;
    int nwrap  = 0;
    int rose   = 0;
    if (stop) begin
      nstate = 0; ncnt = 0;
    end else if (m_state == 0) begin
      if (m_press != 0) begin nstate = 1; nsw = dir ? 7 : 0; ncnt = 0; end
    end else if (m_state == 2) begin
      if (m_press != 0) nstate = 1;
    end else if (m_press != 0) begin
      nstate = 2;
    end else if (m_cnt >= int'(step_div)) begin
      ncnt  = 0;
      nsw   = dir ? (m_sw + 7) % 8 : (m_sw + 1) % 8;
      nwrap = dir ? int'(m_sw == 0) : int'(m_sw == 7);
      if (nwrap != 0 && one_shot) nstate = 0;
    end else begin
      ncnt = m_cnt + 1;
    end
    // consecutive disagreeing samples counted; DEB in a row flips the level
    if (m_s2 != m_deb) begin
      m_dc++;
      if (m_dc == DEB) begin
        m_deb = m_s2; m_dc = 0; rose = int'(m_deb == 1);
      end
    end else begin
      m_dc = 0;
    end
    m_press = rose;
    m_s2 = m_s1;
    m_s1 = int'(run_btn);
    m_state = nstate; m_sw = nsw; m_cnt = ncnt; m_wrap = nwrap;
  endfunction

  task automatic cyc();
    logic [7:0] e;
    model_clock();
    e = model_out();
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic b, input int n);
    run_btn = b;
    repeat (n) cyc();
  endtask

  task automatic press_btn();
    hold(1'b1, 6);
    hold(1'b0, 6);
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", {switch, enable, busy, wrap}, e);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {switch, enable, busy, wrap}, 8'h00);
    rst = 1'b1;

    // Debounce: short pulse ignored, sustained high starts RUN; then up-count.
    step_div = 4'd2; dir = 1'b0;
    hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 10); hold(1'b0, 6);
    repeat (30) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;

    // Down-count, one_shot, step every cycle.
    dir = 1'b1; one_shot = 1'b1; step_div = 4'd0;
    press_btn();
    repeat (10) cyc();
    one_shot = 1'b0;

    // Pause / resume.
    dir = 1'b0; step_div = 4'd3;
    press_btn();
    repeat (8) cyc();
    press_btn();
    repeat (20) cyc();
    press_btn();
    repeat (10) cyc();

    // Pause, then stop coinciding with the next press.
    press_btn();
    run_btn = 1'b1;
    repeat (5) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    hold(1'b1, 3); hold(1'b0, 6);
    stop = 1'b1; repeat (3) cyc(); stop = 1'b0;

    // Reset mid-RUN, ideally at switch=5.
    step_div = 4'd1;
    press_btn();
    for (int i = 0; i < 40 && m_sw != 5; i++) cyc();
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", {switch, enable, busy, wrap}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) cyc();

    // Randomized segments.
    for (int s = 0; s < 120; s++) begin
      int len;
      run_btn  = 1'($urandom_range(0, 1));
      len      = int'($urandom_range(1, 8));
      one_shot = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) step_div = 4'($urandom_range(0, 5));
      stop = ($urandom_range(0, 25) == 0);
      cyc();
      stop = 1'b0;
      repeat (len - 1) cyc();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
